// File: rtl/radix4_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : radix4_mul_pkg
// Brief    : Shared constants for the radix-4 Booth multiplier controller.
//            Signedness selected by RADIX4_MUL_SIGNED_EN.
// Revision : 1.0
// ============================================================================
package radix4_mul_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int CNT_W = 3;

`ifdef RADIX4_MUL_SIGNED_EN
  localparam int N_ITER = 4;
`else
  localparam int N_ITER = 5;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  localparam logic [2:0] BD_Z0  = 3'b000;
  localparam logic [2:0] BD_P1A = 3'b001;
  localparam logic [2:0] BD_P1B = 3'b010;
  localparam logic [2:0] BD_P2  = 3'b011;
  localparam logic [2:0] BD_M2  = 3'b100;
  localparam logic [2:0] BD_M1A = 3'b101;
  localparam logic [2:0] BD_M1B = 3'b110;
  localparam logic [2:0] BD_Z1  = 3'b111;

  function automatic logic [15:0] ext_mcand(input logic [7:0] a);
`ifdef RADIX4_MUL_SIGNED_EN
    return {{8{a[7]}}, a};
`else
    return {8'h00, a};
`endif
  endfunction

  // Two guard bits above b so the top Booth digit sees the extension.
  function automatic logic [10:0] ext_mplr(input logic [7:0] b);
`ifdef RADIX4_MUL_SIGNED_EN
    return {b[7], b[7], b, 1'b0};
`else
    return {2'b00, b, 1'b0};
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : radix4_mul_seq_if
// Brief    : Operand/result handshake bundle for radix4_mul_seq.
// Revision : 1.0
// ============================================================================
interface radix4_mul_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface
`default_nettype wire

// File: rtl/cladder.sv
`default_nettype none
// ============================================================================
// Module   : cladder
// Brief    : 16-bit carry-look-ahead adder, four 4-bit lookahead groups.
// Revision : 1.0
// ============================================================================
module cladder (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  input  wire logic        cin,
  output logic [15:0]      sum,
  output logic             cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic       ci;
    assign gg = g[4*gi +: 4];
    assign pp = p[4*gi +: 4];
    assign ci = c[4*gi];
    assign c[4*gi+1] = gg[0] | (pp[0] & ci);
    assign c[4*gi+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    assign c[4*gi+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & ci);
    assign c[4*gi+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0])
                     | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule
`default_nettype wire

// File: rtl/radix4_mul_seq_booth4_enc.sv
`default_nettype none
// ============================================================================
// Module   : booth4_enc
// Brief    : Radix-4 Booth digit decoder: 3-bit window -> {zero, two, neg}.
// Revision : 1.0
// ============================================================================
module booth4_enc
  import radix4_mul_pkg::*;
(
  input  wire logic [2:0] digit,
  output logic            zero,
  output logic            two,
  output logic            neg
);

  always_comb begin
    zero = 1'b0;
    two  = 1'b0;
    neg  = 1'b0;
    case (digit)
      BD_Z0, BD_Z1:   zero = 1'b1;
      BD_P1A, BD_P1B: ;
      BD_P2:          two  = 1'b1;
      BD_M2: begin
        two = 1'b1;
        neg = 1'b1;
      end
      BD_M1A, BD_M1B: neg  = 1'b1;
      default:        zero = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/radix4_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : radix4_mul_seq
// Brief    : Sequential radix-4 Booth 8x8 multiplier sharing one cladder.
//            RADIX4_MUL_SIGNED_EN selects two's-complement operands.
// Revision : 1.0
// ============================================================================
module radix4_mul_seq
  import radix4_mul_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  radix4_mul_seq_if.slave  bus
);

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      mcand_q, mcand_d;
  logic [10:0]      mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      product_q, product_d;

  logic        dig_zero, dig_two, dig_neg;
  logic [15:0] sel;
  logic [15:0] add_b;
  logic [15:0] sum;
  logic        add_cout_unused;

  booth4_enc u_enc (
    .digit (mplr_q[2:0]),
    .zero  (dig_zero),
    .two   (dig_two),
    .neg   (dig_neg)
  );

  // Negation is one's complement here plus cin=1 in the adder.
  assign sel   = dig_zero ? 16'h0000 : (dig_two ? {mcand_q[14:0], 1'b0} : mcand_q);
  assign add_b = sel ^ {16{dig_neg}};

  cladder u_add (
    .a    (acc_q),
    .b    (add_b),
    .cin  (dig_neg),
    .sum  (sum),
    .cout (add_cout_unused)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_CALC;
          acc_d   = 16'h0000;
          mcand_d = ext_mcand(bus.a);
          mplr_d  = ext_mplr(bus.b);
          cnt_d   = '0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d   = sum;
        mcand_d = {mcand_q[13:0], 2'b00};
        mplr_d  = {mplr_q[10], mplr_q[10], mplr_q[10:2]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          product_d = sum;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == ST_CALC);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_radix4_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix4_mul_seq
// Brief    : Directed self-checking bench with a cycle-level product model.
// Revision : 1.0
// ============================================================================
module tb_radix4_mul_seq;

`ifdef RADIX4_MUL_SIGNED_EN
  localparam int N_EXP = 4;
`else
  localparam int N_EXP = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  radix4_mul_seq_if bus ();

  radix4_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef RADIX4_MUL_SIGNED_EN
    p = $signed(x) * $signed(y);
`else
    p = x * y;
`endif
    return p[15:0];
  endfunction

  // Model: an accepted start yields its product N_EXP edges later; starts while busy are dropped.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_prod = 16'h0000;
  logic [15:0] m_pend = 16'h0000;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= 16'h0000;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) m_prod <= m_pend;
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (bus.start) begin
        m_left <= N_EXP;
        m_pend <= ref_mul(bus.a, bus.b);
      end
    end
  end

  always @(negedge clk) begin
    check("model busy",    {31'd0, bus.busy}, {31'd0, (m_left != 0)});
    check("model done",    {31'd0, bus.done}, {31'd0, m_done});
    check("model product", {16'd0, bus.product}, {16'd0, m_prod});
  end

  task automatic wait_done(output int k);
    bit seen;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input string name);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    check({name, " latency"}, k, N_EXP);
    check({name, " product"}, {16'd0, bus.product}, {16'd0, exp});
  endtask

  initial begin
    int k;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    repeat (3) @(negedge clk);
    check("reset busy",    {31'd0, bus.busy}, 32'd0);
    check("reset done",    {31'd0, bus.done}, 32'd0);
    check("reset product", {16'd0, bus.product}, 32'h0000);
    rst = 1'b0;

`ifdef RADIX4_MUL_SIGNED_EN
    run_op(8'd7,   8'hFD, 16'hFFEB, "7*-3");
    run_op(8'h80,  8'h80, 16'h4000, "-128*-128");
    run_op(8'd127, 8'h80, 16'hC080, "127*-128");
    run_op(8'hFF,  8'hFF, 16'h0001, "-1*-1");
`else
    run_op(8'd255, 8'd255, 16'hFE01, "255*255");
    run_op(8'd0,   8'd200, 16'h0000, "0*200");
    run_op(8'd200, 8'd3,   16'h0258, "200*3");
    run_op(8'd128, 8'd128, 16'h4000, "128*128");
`endif
    run_op(8'd13, 8'd11, 16'h008F, "13*11");

    // Start during CALC must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    check("ignore latency", k, N_EXP - 2);
    check("ignore product", {16'd0, bus.product}, 32'h2710);
    repeat (N_EXP + 2) begin
      @(negedge clk);
      check("ignore single done", {31'd0, bus.done}, 32'd0);
    end

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd120; bus.b = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    check("b2b first product", {16'd0, bus.product}, 32'h0168);
    bus.start = 1'b1; bus.a = 8'd17; bus.b = 8'd15;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b done falls", {31'd0, bus.done}, 32'd0);
    check("b2b product held", {16'd0, bus.product}, 32'h0168);
    wait_done(k);
    check("b2b second latency", k, N_EXP);
    check("b2b second product", {16'd0, bus.product}, 32'h00FF);

    // Reset at iteration 2 aborts the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd50; bus.b = 8'd60;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",    {31'd0, bus.busy}, 32'd0);
    check("abort done",    {31'd0, bus.done}, 32'd0);
    check("abort product", {16'd0, bus.product}, 32'h0000);
    repeat (N_EXP + 2) begin
      @(negedge clk);
      check("abort no done", {31'd0, bus.done}, 32'd0);
    end
    run_op(8'd9, 8'd9, 16'h0051, "9*9 after abort");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
